// File: rtl/syn_down_counter4bit.sv
// Programmable synchronous down-counter with terminal-count pulse, auto-reload
// or one-shot behaviour, and a borrow-in/borrow-out pair for cascading stages.
module syn_down_counter4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clki,
  input  logic             reset,
  input  logic             en,
  input  logic             bin,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             bout
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] rl;
  logic [WIDTH-1:0] rl_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt;
  logic             tick;
  logic             term;

  // A tick only counts while running; term is a tick that lands on zero.
  assign tick = (state == RUN) & en & bin;
  assign term = tick & (q == '0);

  // Borrow-out stays combinational so a cascaded stage decrements on this same edge.
  assign bout = term;
  assign busy = (state == RUN);

  // State, count, reload value and done pulse registers.
  always_ff @(posedge clki or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      q     <= '0;
      rl    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      rl    <= rl_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state logic: load beats terminal count, which beats a plain decrement.
  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    rl_nxt    = rl;
    done_nxt  = 1'b0;
    if (load) begin
      q_nxt     = din;
      rl_nxt    = din;
      state_nxt = RUN;
    end else if (term) begin
      done_nxt = 1'b1;
      if (mode) begin
        state_nxt = IDLE;
      end else begin
        q_nxt = rl;
      end
    end else if (tick) begin
      q_nxt = q - WIDTH'(1);
    end
  end

endmodule

// File: doc/syn_down_counter4bit.md
# syn_down_counter4bit

Programmable synchronous down-counter: the count-down counterpart to the team's 4-bit synchronous up-counter. Loads a start value, decrements by one per enabled clock, and signals terminal count. At zero it either auto-reloads, giving a periodic divider or timer, or stops (one-shot). A borrow-in/borrow-out pair lets instances cascade into wider down-counters or multi-digit timers.

## Interface
- WIDTH, 4, counter and data width in bits.
- clki  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset; one clock domain only.
- en  in  1  count enable.
- bin  in  1  borrow-in (cascade enable); tie high on the least-significant stage.
- load  in  1  synchronous parallel load request.
- din  in  WIDTH  load value; also captured as the reload value.
- mode  in  1  0 = auto-reload, 1 = one-shot; sampled each cycle.
- q  out  WIDTH  current count (registered).
- busy  out  1  high while in RUN (registered).
- done  out  1  one-cycle terminal-count pulse (registered).
- bout  out  1  borrow-out (combinational); drives the next stage's bin.

## Operation
- Internal registers: q, rl (reload value, WIDTH bits), state ∈ {IDLE, RUN}, done.
- tick = (state == RUN) & en & bin.
- term = tick & (q == 0).
- Reset (reset = 0, asynchronous):
  - q = 0, rl = 0, state = IDLE, busy = 0, done = 0, bout = 0.
  - Takes effect immediately, regardless of clki, including mid-count.
- Priority on each rising edge: load > term > tick > hold.
- load = 1 (any state):
  - q ← din, rl ← din, state ← RUN.
  - No decrement that cycle; done ← 0, even if term would otherwise fire.
- term, mode = 0 (auto-reload): q ← rl, state stays RUN, done ← 1.
- term, mode = 1 (one-shot): q stays 0, state ← IDLE, done ← 1.
- tick with q ≠ 0: q ← q − 1, done ← 0.
- Otherwise: q and state hold, done ← 0.
- IDLE: en and bin are ignored; only load leaves IDLE.
- busy = (state == RUN).
- bout = term; it is combinational so cascaded stages decrement on the same edge.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - q never decrements below 0; the 0 state is always handled by term.
  - Auto-reload period = rl + 1 ticks.
  - rl = 0 in auto-reload gives term on every tick, so done stays high continuously while ticking.

## Timing
- q, busy and done update on the rising clki edge after the qualifying inputs are sampled.
- Load latency: 1 edge. q = din and busy = 1 after the edge where load = 1.
- Terminal count: bout is high during the cycle where q = 0 and tick = 1. done is high for exactly one cycle starting at the next edge, coincident with q = rl (auto-reload) or busy = 0 (one-shot).
- Cascade: the upper stage decrements on the same edge the lower stage reloads. There is no extra latency per stage.
- If en drops during a q = 0 cycle, there is no term and no done; the count resumes when en returns.
- reset released (0→1) mid-cycle: the block stays IDLE until a load.

## Test plan
- Reset: assert reset = 0 mid-cycle while RUN at q = 5 → q = 0, busy = 0, done = 0, bout = 0 immediately, before any clki edge. After release, en = 1 for 5 cycles → q stays 0.
- Auto-reload: mode = 0, load din = 3, then en = bin = 1 continuously → q = 3,2,1,0,3,2,1,0. bout high on each q = 0 cycle. done high exactly on each cycle where q returns to 3 (period 4). busy stays 1.
- One-shot: mode = 1, load din = 2 → q = 2,1,0. On the next edge busy = 0, done pulses for one cycle, and q holds at 0. Ten further en cycles → no change.
- Hold and gating: at q = 6, en = 0 for 3 cycles → q stays 6. Then en = 1, bin = 0 for 3 cycles → q stays 6. Then bin = 1 → q = 5.
- Load priority: running at q = 0 with en = 1 (term pending), assert load with din = 9 → q = 9 next edge, done = 0, and subsequent reloads use 9.
- Cascade: two WIDTH = 4 instances, with the low stage's bout driving the high stage's bin. Both load 0xF, auto-reload, en = 1 → the high stage decrements once every 16 cycles. The high stage's done first pulses after 256 cycles.
